// File: rtl/mtimer_channel_scheduler.sv
// Timer channel scheduler: NCH compare channels time-share one 64-bit comparator against mtime.
// A round-robin scan sets PEND and optionally reloads CMP. The channels are exposed as XT bus slave registers.
package mtimer_channel_scheduler_pkg;
   typedef struct packed {
      logic [31:0] raddr;
      logic [31:0] waddr;
      logic [31:0] wdata;
   } hb_slave_t;

   typedef struct packed {
      logic ren;
      logic wen;
   } sel_t;
endpackage

module mtimer_channel_scheduler
   import mtimer_channel_scheduler_pkg::*;
#(
   parameter int NCH = 4
) (
   input  logic        hb_clk,
   input  logic        rst,
   input  logic [63:0] mtime,
   input  hb_slave_t   xt_hb,
   input  sel_t        sel,
   output logic [31:0] rdata,
   output logic        chan_int
);
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [63:0]    cmp_reg    [NCH];
   logic [63:0]    cmp_next   [NCH];
   logic [31:0]    period_reg [NCH];
   logic [31:0]    period_next[NCH];
   logic [NCH-1:0] en_reg, en_next;
   logic [NCH-1:0] pend_reg, pend_next;
   logic [NCH-1:0] per_reg, per_next;
   logic [IW-1:0]  scan_idx_reg, scan_idx_next;
   logic [31:0]    rdata_reg, rdata_next;
   logic           chan_int_reg;

   logic [63:0]    scan_cmp;
   logic [31:0]    scan_period;
   logic [63:0]    reload_val;
   logic           scan_hit;
   logic           wr_chan;
   logic [2:0]     wr_ch;
   logic [1:0]     wr_reg;
   logic [NCH-1:0] wr_sel, hit_sel;
   logic [31:0]    rd_val;
   logic [2:0]     low_idx;
   logic           unused_addr_bits;

   // Single shared comparator and reload adder, steered by the scan index
   assign scan_cmp      = cmp_reg[scan_idx_reg];
   assign scan_period   = period_reg[scan_idx_reg];
   assign scan_hit      = en_reg[scan_idx_reg] && !pend_reg[scan_idx_reg] && (mtime >= scan_cmp);
   assign reload_val    = scan_cmp + {32'd0, scan_period};
   assign scan_idx_next = (scan_idx_reg == IW'(NCH - 1)) ? '0 : scan_idx_reg + 1'b1;

   assign wr_chan = sel.wen && !xt_hb.waddr[7];
   assign wr_ch   = xt_hb.waddr[6:4];
   assign wr_reg  = xt_hb.waddr[3:2];
   assign unused_addr_bits = ^{xt_hb.raddr[31:8], xt_hb.raddr[1:0],
                               xt_hb.waddr[31:8], xt_hb.waddr[1:0]};

   // Any bus write to a channel suppresses that channel's scan hit in the same cycle
   for (genvar gi = 0; gi < NCH; gi++) begin : g_sel
      assign wr_sel[gi]  = wr_chan && (wr_ch == 3'(gi));
      assign hit_sel[gi] = scan_hit && (scan_idx_reg == IW'(gi)) && !wr_sel[gi];
   end

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         cmp_next[c]    = cmp_reg[c];
         period_next[c] = period_reg[c];
         en_next[c]     = en_reg[c];
         pend_next[c]   = pend_reg[c];
         per_next[c]    = per_reg[c];
         if (wr_sel[c]) begin
            case (wr_reg)
               2'd0: begin
                  cmp_next[c][31:0] = xt_hb.wdata;
                  pend_next[c]      = 1'b0;
               end
               2'd1: begin
                  cmp_next[c][63:32] = xt_hb.wdata;
                  pend_next[c]       = 1'b0;
               end
               2'd2: begin
                  en_next[c]  = xt_hb.wdata[0];
                  per_next[c] = xt_hb.wdata[2];
                  if (xt_hb.wdata[1]) pend_next[c] = 1'b0;
               end
               default: period_next[c] = xt_hb.wdata;
            endcase
         end else if (hit_sel[c]) begin
            pend_next[c] = 1'b1;
            if (per_reg[c] && (period_reg[c] != 32'd0)) cmp_next[c] = reload_val;
         end
      end
   end

   always_comb begin
      low_idx = '0;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (pend_reg[c]) low_idx = 3'(c);
      end
   end

   always_comb begin
      rd_val = '0;
      if (!xt_hb.raddr[7]) begin
         for (int c = 0; c < NCH; c++) begin
            if (xt_hb.raddr[6:4] == 3'(c)) begin
               case (xt_hb.raddr[3:2])
                  2'd0:    rd_val = cmp_reg[c][31:0];
                  2'd1:    rd_val = cmp_reg[c][63:32];
                  2'd2:    rd_val = {29'd0, per_reg[c], pend_reg[c], en_reg[c]};
                  default: rd_val = period_reg[c];
               endcase
            end
         end
      end else if (xt_hb.raddr[7:2] == 6'h20) begin
         rd_val = 32'(pend_reg);
      end else if (xt_hb.raddr[7:2] == 6'h21) begin
         rd_val = {|pend_reg, 28'd0, low_idx};
      end
   end

   assign rdata_next = sel.ren ? rd_val : rdata_reg;

   always_ff @(posedge hb_clk) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            cmp_reg[c]    <= '0;
            period_reg[c] <= '0;
         end
         en_reg       <= '0;
         pend_reg     <= '0;
         per_reg      <= '0;
         scan_idx_reg <= '0;
         rdata_reg    <= '0;
         chan_int_reg <= 1'b0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            cmp_reg[c]    <= cmp_next[c];
            period_reg[c] <= period_next[c];
         end
         en_reg       <= en_next;
         pend_reg     <= pend_next;
         per_reg      <= per_next;
         scan_idx_reg <= scan_idx_next;
         rdata_reg    <= rdata_next;
         // Built from next-state so the interrupt moves on the same edge as PEND
         chan_int_reg <= |(pend_next & en_next);
      end
   end

   assign rdata    = rdata_reg;
   assign chan_int = chan_int_reg;
endmodule

// File: tb/tb_mtimer_channel_scheduler.sv
// Bench for mtimer_channel_scheduler: a table-driven one-shot run, directed corner sequences
// and randomized traffic, all checked against a cycle-level model of the register behaviour.
module tb_mtimer_channel_scheduler;
   import mtimer_channel_scheduler_pkg::*;

   localparam int NCH = 4;

   logic        hb_clk;
   logic        rst;
   logic [63:0] mtime;
   hb_slave_t   xt_hb;
   sel_t        sel;
   logic [31:0] rdata;
   logic        chan_int;

   mtimer_channel_scheduler #(.NCH(NCH)) dut (
      .hb_clk  (hb_clk),
      .rst     (rst),
      .mtime   (mtime),
      .xt_hb   (xt_hb),
      .sel     (sel),
      .rdata   (rdata),
      .chan_int(chan_int)
   );

   initial hb_clk = 1'b0;
   always #5 hb_clk = ~hb_clk;

   typedef struct {
      logic        rst;
      logic        wen;
      logic [7:0]  waddr;
      logic [31:0] wdata;
      logic        ren;
      logic [7:0]  raddr;
      logic [63:0] mt;
      logic [31:0] exp_rd;
      logic        exp_int;
   } vec_t;

   vec_t tbl[20];

   int n_vec  = 0;
   int n_miss = 0;

   // Reference state: what software would see, advanced once per clock
   logic [63:0] m_cmp[NCH];
   logic [31:0] m_period[NCH];
   bit          m_en[NCH];
   bit          m_pend[NCH];
   bit          m_per[NCH];
   logic [31:0] m_rdata;
   bit          m_int;
   int          m_cyc;

   int          r, ch, rg;
   logic [31:0] d;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [7:0] addr);
      logic [7:0]  a;
      logic [31:0] v;
      int          c;
      a = addr & 8'hFC;
      v = '0;
      if (a < 8'h80) begin
         c = int'(a[6:4]);
         if (c < NCH) begin
            case (a[3:2])
               2'd0:    v = m_cmp[c][31:0];
               2'd1:    v = m_cmp[c][63:32];
               2'd2:    v = {29'd0, m_per[c], m_pend[c], m_en[c]};
               default: v = m_period[c];
            endcase
         end
      end else if (a == 8'h80) begin
         for (int k = 0; k < NCH; k++) if (m_pend[k]) v[k] = 1'b1;
      end else if (a == 8'h84) begin
         for (int k = NCH - 1; k >= 0; k--) if (m_pend[k]) v = 32'h8000_0000 | 32'(k);
      end
      return v;
   endfunction

   task automatic model_step();
      int         s, wc, wr;
      bit         wv;
      logic [7:0] wa;
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            m_cmp[k] = '0; m_period[k] = '0;
            m_en[k] = 0; m_pend[k] = 0; m_per[k] = 0;
         end
         m_rdata = '0;
         m_int   = 0;
         m_cyc   = 0;
         return;
      end
      s = m_cyc % NCH;
      if (sel.ren) m_rdata = model_read(xt_hb.raddr[7:0]);
      wa = xt_hb.waddr[7:0];
      wc = int'(wa[6:4]);
      wr = int'(wa[3:2]);
      wv = sel.wen && !wa[7] && (wc < NCH);
      if (m_en[s] && !m_pend[s] && mtime >= m_cmp[s] && !(wv && wc == s)) begin
         m_pend[s] = 1;
         if (m_per[s] && m_period[s] != 0) m_cmp[s] = m_cmp[s] + {32'd0, m_period[s]};
      end
      if (wv) begin
         case (wr)
            0: begin m_cmp[wc][31:0] = xt_hb.wdata; m_pend[wc] = 0; end
            1: begin m_cmp[wc][63:32] = xt_hb.wdata; m_pend[wc] = 0; end
            2: begin
               m_en[wc]  = xt_hb.wdata[0];
               m_per[wc] = xt_hb.wdata[2];
               if (xt_hb.wdata[1]) m_pend[wc] = 0;
            end
            default: m_period[wc] = xt_hb.wdata;
         endcase
      end
      m_int = 0;
      for (int k = 0; k < NCH; k++) if (m_pend[k] && m_en[k]) m_int = 1;
      m_cyc++;
   endtask

   task automatic tick();
      @(posedge hb_clk);
      model_step();
      #1;
      chk("model_rdata", 64'(rdata), 64'(m_rdata));
      chk("model_int", 64'(chan_int), 64'(m_int));
      sel = '0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] v);
      sel.wen = 1'b1;
      xt_hb.waddr = 32'(a);
      xt_hb.wdata = v;
      tick();
   endtask

   task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
      sel.ren = 1'b1;
      xt_hb.raddr = 32'(a);
      tick();
      chk(name, 64'(rdata), 64'(exp));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_int(input string name, input int max_cycles);
      int k;
      k = 0;
      while (!chan_int && k < max_cycles) begin
         tick();
         k++;
      end
      chk(name, 64'(chan_int), 64'd1);
   endtask

   initial begin
      rst = 1'b1;
      sel = '0;
      xt_hb = '0;
      mtime = '0;

      // One-shot on ch2: CMP=100, mtime counts up from 90, scan hits ch2 on row 11
      for (int i = 0; i < 20; i++) begin
         tbl[i].rst     = (i == 0);
         tbl[i].wen     = 1'b0;
         tbl[i].waddr   = '0;
         tbl[i].wdata   = '0;
         tbl[i].ren     = 1'b0;
         tbl[i].raddr   = '0;
         tbl[i].mt      = 64'(89 + i);
         tbl[i].exp_rd  = (i >= 3 && i <= 10) ? 32'd100 : 32'd0;
         tbl[i].exp_int = (i >= 11 && i <= 13);
      end
      tbl[1].wen  = 1'b1; tbl[1].waddr = 8'h20; tbl[1].wdata = 32'd100;
      tbl[2].wen  = 1'b1; tbl[2].waddr = 8'h28; tbl[2].wdata = 32'd1;
      tbl[3].ren  = 1'b1; tbl[3].raddr = 8'h20;
      tbl[11].ren = 1'b1; tbl[11].raddr = 8'h80;
      tbl[12].ren = 1'b1; tbl[12].raddr = 8'h84; tbl[12].exp_rd = 32'h8000_0002;
      tbl[13].ren = 1'b1; tbl[13].raddr = 8'h80; tbl[13].exp_rd = 32'd4;
      tbl[14].wen = 1'b1; tbl[14].waddr = 8'h28; tbl[14].wdata = 32'd2; tbl[14].exp_rd = 32'd4;
      tbl[15].ren = 1'b1; tbl[15].raddr = 8'h84;

      for (int i = 0; i < 20; i++) begin
         rst         = tbl[i].rst;
         sel.wen     = tbl[i].wen;
         sel.ren     = tbl[i].ren;
         xt_hb.waddr = 32'(tbl[i].waddr);
         xt_hb.wdata = tbl[i].wdata;
         xt_hb.raddr = 32'(tbl[i].raddr);
         mtime       = tbl[i].mt;
         tick();
         $display("vec %0d: rdata=0x%08h chan_int=%0d", i, rdata, chan_int);
         chk($sformatf("tbl%0d_rdata", i), 64'(rdata), 64'(tbl[i].exp_rd));
         chk($sformatf("tbl%0d_int", i), 64'(chan_int), 64'(tbl[i].exp_int));
      end
      rst = 1'b0;

      // Periodic reload on ch0
      mtime = '0;
      do_reset();
      wr(8'h00, 32'd50);
      wr(8'h0C, 32'd20);
      wr(8'h08, 32'd5);
      mtime = 64'd50;
      wait_int("periodic_fire1", 8);
      rd("periodic_cmp70", 8'h00, 32'd70);
      wr(8'h08, 32'd7);
      chk("periodic_clear", 64'(chan_int), 64'd0);
      repeat (6) tick();
      chk("periodic_no_early", 64'(chan_int), 64'd0);
      mtime = 64'd70;
      wait_int("periodic_fire2", 8);
      rd("periodic_cmp90", 8'h00, 32'd90);

      // 64-bit wrap of the reload on ch1
      do_reset();
      wr(8'h10, 32'hFFFF_FFF0);
      wr(8'h14, 32'hFFFF_FFFF);
      wr(8'h1C, 32'h20);
      wr(8'h18, 32'd5);
      mtime = '1;
      wait_int("wrap_fire", 8);
      rd("wrap_cmp_l", 8'h10, 32'h10);
      rd("wrap_cmp_h", 8'h14, 32'h0);

      // Priority between ch1 and ch3 (CMP=0, so both fire as soon as enabled)
      mtime = 64'd5;
      do_reset();
      wr(8'h38, 32'd1);
      wr(8'h18, 32'd1);
      repeat (6) tick();
      rd("prio_status", 8'h80, 32'hA);
      rd("prio_active1", 8'h84, 32'h8000_0001);
      wr(8'h18, 32'd2);
      rd("prio_active3", 8'h84, 32'h8000_0003);

      // Collision: CMP_L write on the very cycle ch0 would hit
      mtime = 64'd1000;
      do_reset();
      wr(8'h08, 32'd1);
      repeat (3) tick();
      wr(8'h00, 32'd500);
      chk("coll_no_pend", 64'(chan_int), 64'd0);
      rd("coll_status", 8'h80, 32'd0);
      tick();
      tick();
      chk("coll_still_idle", 64'(chan_int), 64'd0);
      tick();
      chk("coll_next_lap", 64'(chan_int), 64'd1);

      // Reset while ch0 is pending
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_int", 64'(chan_int), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      rd("rst_status", 8'h80, 32'd0);
      rd("rst_cmp0", 8'h00, 32'd0);

      // Randomized traffic against the model
      mtime = 64'h0000_0001_FFFF_FF00;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         mtime = mtime + 64'($urandom_range(0, 3));
         rst = (r < 2);
         if (r >= 2 && r < 35) begin
            ch = $urandom_range(0, 8);
            rg = $urandom_range(0, 3);
            case (rg)
               0:       d = mtime[31:0] + 32'($urandom_range(0, 40));
               1:       d = mtime[63:32];
               2:       d = 32'($urandom_range(0, 7));
               default: d = 32'($urandom_range(0, 30));
            endcase
            sel.wen = 1'b1;
            xt_hb.waddr = 32'(ch * 16 + rg * 4);
            xt_hb.wdata = d;
         end
         if (r >= 20) begin
            sel.ren = 1'b1;
            xt_hb.raddr = 32'($urandom_range(0, 8) * 16 + $urandom_range(0, 3) * 4);
         end
         tick();
      end
      rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
